// File: rtl/load_store_unit_if.sv
// Bus interface between load_store_unit and the data memory.
// One valid/ready request channel plus a read-data return channel.
//   busValid  master->slave  request valid; Addr/Write/WData/Strb stable while high
//   busWrite  master->slave  1 store, 0 load
//   busAddr   master->slave  word-aligned byte address
//   busWData  master->slave  lane-replicated store data
//   busStrb   master->slave  byte enables
//   busReady  slave->master  request accepted this cycle
//   busRValid slave->master  load data valid this cycle
//   busRData  slave->master  load word
interface load_store_unit_if;
  logic        busValid;
  logic        busWrite;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [3:0]  busStrb;
  logic        busReady;
  logic        busRValid;
  logic [31:0] busRData;

  modport master (
    output busValid, busWrite, busAddr, busWData, busStrb,
    input  busReady, busRValid, busRData
  );

  modport slave (
    input  busValid, busWrite, busAddr, busWData, busStrb,
    output busReady, busRValid, busRData
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory stage behind the datapath. Runs one bus
// transaction per load/store, right-aligns load data and stalls the core
// until the access completes. Sign/zero extension is left to the datapath.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses without issuing a bus request.
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_memRead, i_memWrite   access request levels (store wins)
//   i_memSize               00 byte, 01 half, 1x word
//   i_addr, i_writeData     byte address, right-aligned store data
//   o_readData              aligned load data, valid in DONE, else 0
//   o_stall                 core hold
//   o_busErr                one-cycle pulse in DONE on timeout
//   o_misaligned            one-cycle pulse in DONE on trapped access
//   bus                     master side of load_store_unit_if
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_memRead,
  input  logic              i_memWrite,
  input  logic [1:0]        i_memSize,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_writeData,
  output logic [31:0]       o_readData,
  output logic              o_stall,
  output logic              o_busErr,
  output logic              o_misaligned,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;

  logic        req;
  logic        timeout;
  logic        misalign_hit;
  logic        valid;
  logic [4:0]  lane_shift;
  logic [31:0] load_aligned;
  logic [3:0]  strb;
  logic [31:0] wdata;

  assign req          = i_memRead | i_memWrite;
  assign timeout      = (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign lane_shift   = {i_addr[1:0], 3'b000};
  assign load_aligned = bus.busRData >> lane_shift;

`ifdef MISALIGN_TRAP_EN
  assign misalign_hit = (i_memSize == 2'b01) ? i_addr[0]
                      : (i_memSize[1] && (i_addr[1:0] != 2'b00));
`else
  assign misalign_hit = 1'b0;
`endif

  // Lane steering: half uses only a[1], word ignores the low address bits.
  always_comb begin
    strb  = 4'b1111;
    wdata = i_writeData;
    case (i_memSize)
      2'b00: begin
        strb  = 4'b0001 << i_addr[1:0];
        wdata = {4{i_writeData[7:0]}};
      end
      2'b01: begin
        strb  = 4'b0011 << {i_addr[1], 1'b0};
        wdata = {2{i_writeData[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          rdata_d = '0;
          if (misalign_hit) begin
            state_d = DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        // Valid is withdrawn in the abort cycle so no handshake can race it.
        if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          valid = 1'b1;
          if (bus.busReady) begin
            if (i_memWrite) begin
              state_d = DONE;
            end else if (bus.busRValid) begin
              state_d = DONE;
              rdata_d = load_aligned;
            end else begin
              state_d = RESP;
            end
          end
        end
      end
      RESP: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (bus.busRValid) begin
          state_d = DONE;
          rdata_d = load_aligned;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign bus.busValid = valid;
  assign bus.busWrite = valid & i_memWrite;
  assign bus.busAddr  = valid ? {i_addr[31:2], 2'b00} : '0;
  assign bus.busWData = valid ? wdata : '0;
  assign bus.busStrb  = valid ? strb : '0;

  // Reset gates the stall so the core is released while the FSM is held.
  assign o_stall      = req & (state_q != DONE) & ~i_reset;
  assign o_readData   = (state_q == DONE && !err_q && !mis_q) ? rdata_q : '0;
  assign o_busErr     = (state_q == DONE) & err_q;
  assign o_misaligned = (state_q == DONE) & mis_q;

endmodule
